// File: rtl/usb_txn_sequencer.sv
// Host-side USB transaction sequencer: drives sender strobes for OUT/IN transactions,
// watches receiver results, retries on failure and reports completion status.
module usb_txn_sequencer #(
   parameter int unsigned MAX_RETRY   = 8,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        txn_start,
   input  logic        txn_is_in,
   input  logic [3:0]  txn_endp,
   input  logic [63:0] txn_wdata,
   output logic        busy,
   output logic        txn_done,
   output logic        txn_success,
   output logic [63:0] txn_rdata,
   output logic        send_OUT,
   output logic        send_IN,
   output logic        send_DATA0,
   output logic        send_ACK,
   output logic        send_NAK,
   output logic [3:0]  endp,
   output logic [63:0] data,
   input  logic        out_done,
   output logic        rx_enable,
   input  logic        rx_ack,
   input  logic        rx_nak,
   input  logic        rx_data0,
   input  logic        rx_error,
   input  logic [63:0] rx_payload
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_TOKEN, S_TOK_WAIT, S_DATA, S_DATA_WAIT, S_RX_HS,
      S_RX_DATA, S_SEND_ACK, S_ACK_WAIT, S_RETRY, S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic          is_in_q, is_in_nxt;
   logic          ok_q, ok_nxt;
   logic [RW-1:0] retry_q, retry_nxt;
   logic [TW-1:0] tmo_q, tmo_nxt;
   logic [3:0]    endp_nxt;
   logic [63:0]   data_nxt, rdata_nxt;
   logic          success_nxt, done_nxt, busy_nxt, rxen_nxt;
   logic          send_out_nxt, send_in_nxt, send_data0_nxt, send_ack_nxt;
   logic          timeout_c, tmo_inc_c;

   // The host never NAKs a device
   assign send_NAK = 1'b0;

   // Timeout fires on the TIMEOUT_CYC-th cycle spent in an RX wait state
   assign timeout_c = (tmo_q == TW'(TIMEOUT_CYC - 1));
   assign tmo_inc_c = (tmo_q != TW'(TIMEOUT_CYC));

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         is_in_q     <= 1'b0;
         ok_q        <= 1'b0;
         retry_q     <= '0;
         tmo_q       <= '0;
         endp        <= '0;
         data        <= '0;
         txn_rdata   <= '0;
         txn_success <= 1'b0;
         txn_done    <= 1'b0;
         busy        <= 1'b0;
         rx_enable   <= 1'b0;
         send_OUT    <= 1'b0;
         send_IN     <= 1'b0;
         send_DATA0  <= 1'b0;
         send_ACK    <= 1'b0;
      end else begin
         state       <= state_nxt;
         is_in_q     <= is_in_nxt;
         ok_q        <= ok_nxt;
         retry_q     <= retry_nxt;
         tmo_q       <= tmo_nxt;
         endp        <= endp_nxt;
         data        <= data_nxt;
         txn_rdata   <= rdata_nxt;
         txn_success <= success_nxt;
         txn_done    <= done_nxt;
         busy        <= busy_nxt;
         rx_enable   <= rxen_nxt;
         send_OUT    <= send_out_nxt;
         send_IN     <= send_in_nxt;
         send_DATA0  <= send_data0_nxt;
         send_ACK    <= send_ack_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      is_in_nxt      = is_in_q;
      ok_nxt         = ok_q;
      retry_nxt      = retry_q;
      tmo_nxt        = tmo_q;
      endp_nxt       = endp;
      data_nxt       = data;
      rdata_nxt      = txn_rdata;
      success_nxt    = txn_success;
      done_nxt       = 1'b0;
      send_out_nxt   = 1'b0;
      send_in_nxt    = 1'b0;
      send_data0_nxt = 1'b0;
      send_ack_nxt   = 1'b0;

      case (state)
         S_IDLE: begin
            if (txn_start) begin
               state_nxt   = S_TOKEN;
               is_in_nxt   = txn_is_in;
               endp_nxt    = txn_endp;
               data_nxt    = txn_wdata;
               retry_nxt   = '0;
               ok_nxt      = 1'b0;
               success_nxt = 1'b0;
            end
         end
         S_TOKEN: begin
            send_out_nxt = ~is_in_q;
            send_in_nxt  = is_in_q;
            state_nxt    = S_TOK_WAIT;
         end
         S_TOK_WAIT: begin
            if (out_done) begin
               state_nxt = is_in_q ? S_RX_DATA : S_DATA;
               tmo_nxt   = '0;
            end
         end
         S_DATA: begin
            send_data0_nxt = 1'b1;
            state_nxt      = S_DATA_WAIT;
         end
         S_DATA_WAIT: begin
            if (out_done) begin
               state_nxt = S_RX_HS;
               tmo_nxt   = '0;
            end
         end
         // Any receiver event outranks the timeout; only a clean ACK completes
         S_RX_HS: begin
            if (tmo_inc_c) tmo_nxt = tmo_q + TW'(1);
            if (rx_error || rx_nak) begin
               state_nxt = S_RETRY;
            end else if (rx_ack) begin
               state_nxt = S_DONE;
               ok_nxt    = 1'b1;
            end else if (rx_data0 || timeout_c) begin
               state_nxt = S_RETRY;
            end
         end
         S_RX_DATA: begin
            if (tmo_inc_c) tmo_nxt = tmo_q + TW'(1);
            if (rx_error || rx_nak || rx_ack) begin
               state_nxt = S_RETRY;
            end else if (rx_data0) begin
               rdata_nxt = rx_payload;
               state_nxt = S_SEND_ACK;
            end else if (timeout_c) begin
               state_nxt = S_RETRY;
            end
         end
         S_SEND_ACK: begin
            send_ack_nxt = 1'b1;
            state_nxt    = S_ACK_WAIT;
         end
         S_ACK_WAIT: begin
            if (out_done) begin
               state_nxt = S_DONE;
               ok_nxt    = 1'b1;
            end
         end
         S_RETRY: begin
            if (retry_q == RW'(MAX_RETRY)) begin
               state_nxt = S_DONE;
               ok_nxt    = 1'b0;
            end else begin
               retry_nxt = retry_q + RW'(1);
               state_nxt = S_TOKEN;
            end
         end
         S_DONE: begin
            done_nxt    = 1'b1;
            success_nxt = ok_q;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      busy_nxt = (state_nxt != S_IDLE);
      rxen_nxt = (state_nxt == S_RX_HS) || (state_nxt == S_RX_DATA);
   end

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// Scoreboard bench for usb_txn_sequencer: directed transactions with a scripted device,
// expected results queued at issue and checked by a monitor on each txn_done.
module tb_usb_txn_sequencer;

   localparam int LIMIT = 600;

   logic        clock = 1'b0;
   logic        reset, start_a, start_b, txn_is_in, out_done;
   logic        rx_ack, rx_nak, rx_data0, rx_error;
   logic [3:0]  txn_endp;
   logic [63:0] txn_wdata, rx_payload;

   logic        a_busy, a_done, a_succ, a_sout, a_sin, a_sd0, a_sack, a_snak, a_rxen;
   logic        b_busy, b_done, b_succ, b_sout, b_sin, b_sd0, b_sack, b_snak, b_rxen;
   logic [3:0]  a_endp, b_endp;
   logic [63:0] a_rdata, b_rdata, a_data, b_data;

   logic        use_b;
   logic        o_busy, o_done, o_succ, o_sout, o_sin, o_sd0, o_sack, o_snak, o_rxen;
   logic [3:0]  o_endp;
   logic [63:0] o_rdata, o_data;

   always #5 clock = ~clock;

   usb_txn_sequencer #(.MAX_RETRY(8), .TIMEOUT_CYC(255)) u_a (
      .clock(clock), .reset(reset), .txn_start(start_a), .txn_is_in(txn_is_in),
      .txn_endp(txn_endp), .txn_wdata(txn_wdata), .busy(a_busy), .txn_done(a_done),
      .txn_success(a_succ), .txn_rdata(a_rdata), .send_OUT(a_sout), .send_IN(a_sin),
      .send_DATA0(a_sd0), .send_ACK(a_sack), .send_NAK(a_snak), .endp(a_endp),
      .data(a_data), .out_done(out_done), .rx_enable(a_rxen), .rx_ack(rx_ack),
      .rx_nak(rx_nak), .rx_data0(rx_data0), .rx_error(rx_error), .rx_payload(rx_payload));

   usb_txn_sequencer #(.MAX_RETRY(2), .TIMEOUT_CYC(255)) u_b (
      .clock(clock), .reset(reset), .txn_start(start_b), .txn_is_in(txn_is_in),
      .txn_endp(txn_endp), .txn_wdata(txn_wdata), .busy(b_busy), .txn_done(b_done),
      .txn_success(b_succ), .txn_rdata(b_rdata), .send_OUT(b_sout), .send_IN(b_sin),
      .send_DATA0(b_sd0), .send_ACK(b_sack), .send_NAK(b_snak), .endp(b_endp),
      .data(b_data), .out_done(out_done), .rx_enable(b_rxen), .rx_ack(rx_ack),
      .rx_nak(rx_nak), .rx_data0(rx_data0), .rx_error(rx_error), .rx_payload(rx_payload));

   assign o_busy  = use_b ? b_busy  : a_busy;
   assign o_done  = use_b ? b_done  : a_done;
   assign o_succ  = use_b ? b_succ  : a_succ;
   assign o_sout  = use_b ? b_sout  : a_sout;
   assign o_sin   = use_b ? b_sin   : a_sin;
   assign o_sd0   = use_b ? b_sd0   : a_sd0;
   assign o_sack  = use_b ? b_sack  : a_sack;
   assign o_snak  = use_b ? b_snak  : a_snak;
   assign o_rxen  = use_b ? b_rxen  : a_rxen;
   assign o_endp  = use_b ? b_endp  : a_endp;
   assign o_rdata = use_b ? b_rdata : a_rdata;
   assign o_data  = use_b ? b_data  : a_data;

   typedef struct {
      logic        success;
      logic        chk_rdata;
      logic [63:0] rdata;
      int          n_out, n_in, n_d0, n_ack, n_rxen;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   c_out, c_in, c_d0, c_ack, c_nak, c_rxen;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Monitor: counts strobes per transaction and scores each completion
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         c_out = 0; c_in = 0; c_d0 = 0; c_ack = 0; c_nak = 0; c_rxen = 0;
      end else begin
         if (o_sout) c_out++;
         if (o_sin)  c_in++;
         if (o_sd0)  c_d0++;
         if (o_sack) c_ack++;
         if (o_snak) c_nak++;
         if (o_rxen) c_rxen++;
         if (o_done) begin
            if (exp_q.size() == 0) begin
               check("expected_queue_nonempty", 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               check("txn_success", 64'(o_succ), 64'(e.success));
               if (e.chk_rdata) check("txn_rdata", o_rdata, e.rdata);
               check("n_send_OUT",   64'(c_out),  64'(e.n_out));
               check("n_send_IN",    64'(c_in),   64'(e.n_in));
               check("n_send_DATA0", 64'(c_d0),   64'(e.n_d0));
               check("n_send_ACK",   64'(c_ack),  64'(e.n_ack));
               check("n_send_NAK",   64'(c_nak),  64'd0);
               check("n_rx_enable",  64'(c_rxen), 64'(e.n_rxen));
            end
            c_out = 0; c_in = 0; c_d0 = 0; c_ack = 0; c_nak = 0; c_rxen = 0;
         end
      end
   end

   function automatic logic sig(input int which);
      case (which)
         0:       return o_sout;
         1:       return o_sin;
         2:       return o_sd0;
         3:       return o_sack;
         4:       return o_rxen;
         default: return o_done;
      endcase
   endfunction

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic wait_for(input int which, input string name);
      int n = 0;
      while (!sig(which) && n < LIMIT) begin
         tick();
         n++;
      end
      check({"wait_", name}, 64'(sig(which)), 64'd1);
   endtask

   task automatic pulse_done();
      out_done = 1'b1;
      tick();
      out_done = 1'b0;
   endtask

   // kind bits: 1=ack 2=nak 4=data0 8=error
   task automatic rx(input int kind);
      wait_for(4, "rx_enable");
      rx_ack   = kind[0];
      rx_nak   = kind[1];
      rx_data0 = kind[2];
      rx_error = kind[3];
      tick();
      {rx_ack, rx_nak, rx_data0, rx_error} = 4'b0;
   endtask

   task automatic out_attempt(input int kind);
      wait_for(0, "send_OUT");
      pulse_done();
      wait_for(2, "send_DATA0");
      pulse_done();
      rx(kind);
   endtask

   task automatic in_attempt(input int kind, input logic [63:0] payload);
      wait_for(1, "send_IN");
      pulse_done();
      rx_payload = payload;
      rx(kind);
      if (kind == 4) begin
         wait_for(3, "send_ACK");
         pulse_done();
      end
   endtask

   task automatic start(input logic b, input logic is_in, input logic [3:0] ep,
                        input logic [63:0] wd);
      use_b     = b;
      txn_is_in = is_in;
      txn_endp  = ep;
      txn_wdata = wd;
      if (b) start_b = 1'b1; else start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic push(input logic s, input logic cr, input logic [63:0] rd,
                       input int no, input int ni, input int nd, input int na, input int nr);
      exp_t e;
      e.success = s; e.chk_rdata = cr; e.rdata = rd;
      e.n_out = no; e.n_in = ni; e.n_d0 = nd; e.n_ack = na; e.n_rxen = nr;
      exp_q.push_back(e);
   endtask

   task automatic wait_done();
      wait_for(5, "txn_done");
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic any;
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; use_b = 1'b0;
      txn_is_in = 1'b0; txn_endp = '0; txn_wdata = '0; out_done = 1'b0;
      {rx_ack, rx_nak, rx_data0, rx_error} = 4'b0; rx_payload = '0;
      repeat (3) tick();
      check("reset_busy", 64'({a_busy, b_busy}), 64'd0);
      check("reset_done_success", 64'({a_done, a_succ, b_done, b_succ}), 64'd0);
      check("reset_strobes", 64'({a_sout, a_sin, a_sd0, a_sack, a_snak, b_sout, b_sin, b_sd0, b_sack, b_snak}), 64'd0);
      check("reset_rx_enable", 64'({a_rxen, b_rxen}), 64'd0);
      check("reset_rdata", a_rdata | b_rdata, 64'd0);
      check("reset_endp_data", a_data | 64'(a_endp), 64'd0);
      reset = 1'b0;
      tick();

      // 1: OUT, ACK first time; 2-cycle strobe latency, latched endp/data
      push(1'b1, 1'b0, 64'd0, 1, 0, 1, 0, 1);
      start(1'b0, 1'b0, 4'd4, 64'h0f21000000000000);
      check("t1_busy_after_accept", 64'(o_busy), 64'd1);
      check("t1_no_early_strobe", 64'(o_sout), 64'd0);
      tick();
      check("t1_send_OUT_latency", 64'(o_sout), 64'd1);
      check("t1_endp", 64'(o_endp), 64'd4);
      check("t1_data", o_data, 64'h0f21000000000000);
      out_attempt(1);
      wait_done();

      // 2: IN on the MAX_RETRY=2 instance, good data first time
      push(1'b1, 1'b1, 64'h40aa11b7682df6d8, 0, 1, 0, 1, 1);
      start(1'b1, 1'b1, 4'd8, 64'd0);
      in_attempt(4, 64'h40aa11b7682df6d8);
      wait_done();

      // 3: OUT, NAK three times then ACK
      push(1'b1, 1'b0, 64'd0, 4, 0, 4, 0, 4);
      start(1'b0, 1'b0, 4'd2, 64'h1122334455667788);
      for (int i = 0; i < 3; i++) out_attempt(2);
      out_attempt(1);
      wait_done();

      // 4: IN, silent device, 3 attempts of 255 cycles each, rdata held
      push(1'b0, 1'b1, 64'h40aa11b7682df6d8, 0, 3, 0, 0, 765);
      start(1'b1, 1'b1, 4'd8, 64'd0);
      for (int i = 0; i < 3; i++) begin
         wait_for(1, "send_IN");
         pulse_done();
      end
      wait_done();

      // 5: IN; error, NAK on the timeout cycle, data0+error together, then good data
      push(1'b1, 1'b1, 64'h123456789abcdef0, 0, 4, 0, 1, 258);
      start(1'b0, 1'b1, 4'd1, 64'd0);
      in_attempt(8, 64'hdeadbeefdeadbeef);
      wait_for(1, "send_IN");
      pulse_done();
      wait_for(4, "rx_enable");
      repeat (254) tick();
      rx_nak = 1'b1;
      tick();
      rx_nak = 1'b0;
      in_attempt(12, 64'hbadbadbadbadbad0);
      in_attempt(4, 64'h123456789abcdef0);
      wait_done();

      // 6: reset in DATA_WAIT, then a start while busy is dropped
      start(1'b0, 1'b0, 4'd3, 64'h00000000cafef00d);
      wait_for(0, "send_OUT");
      pulse_done();
      wait_for(2, "send_DATA0");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_busy_after_reset", 64'(o_busy), 64'd0);
      check("t6_strobes_after_reset", 64'({o_sout, o_sin, o_sd0, o_sack, o_rxen, o_done}), 64'd0);
      pulse_done();
      any = 1'b0;
      repeat (10) begin
         any = any | o_busy | o_sout | o_sin | o_sd0 | o_sack | o_rxen | o_done;
         tick();
      end
      check("t6_idle_after_reset", 64'(any), 64'd0);

      push(1'b1, 1'b0, 64'd0, 1, 0, 1, 0, 1);
      start(1'b0, 1'b0, 4'd5, 64'h5555aaaa5555aaaa);
      wait_for(0, "send_OUT");
      txn_is_in = 1'b1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      pulse_done();
      wait_for(2, "send_DATA0");
      pulse_done();
      rx(1);
      wait_done();
      repeat (6) tick();
      check("t6_start_while_busy_ignored", 64'(o_busy), 64'd0);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
